// File: rtl/hood_mode_ctrl.sv
// Cooker-hood fan mode controller: menu-driven gear selection, timed gear 3 with
// gear-2 run-down, and a timed self-clean cycle. Optional HOOD_GEAR3_ONCE_EN limits gear 3 to one use per power-on.
module hood_mode_ctrl #(
  parameter int unsigned GEAR3_SEC    = 60,
  parameter int unsigned COOLDOWN_SEC = 60,
  parameter int unsigned CLEAN_SEC    = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       power_on,
  input  logic       menu_btn,
  input  logic       mode1_btn,
  input  logic       mode2_btn,
  input  logic       mode3_btn,
  input  logic       clean_btn,
  output logic [2:0] mode_state,
  output logic       menu_active,
  output logic [7:0] remain_sec,
  output logic       clean_done,
  output logic       gear3_avail
);

  typedef enum logic [2:0] {
    S_OFF, S_STANDBY, S_MENU, S_GEAR1, S_GEAR2, S_GEAR3, S_COOLDOWN, S_CLEAN
  } state_t;

  typedef enum logic [2:0] {
    M_IDLE  = 3'b000,
    M_GEAR1 = 3'b001,
    M_GEAR2 = 3'b010,
    M_GEAR3 = 3'b011,
    M_CLEAN = 3'b100
  } mode_t;

  localparam logic [7:0] GEAR3_LOAD    = 8'(GEAR3_SEC);
  localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_SEC);
  localparam logic [7:0] CLEAN_LOAD    = 8'(CLEAN_SEC);

  state_t     state, state_nxt;
  logic [7:0] remain_nxt;
  logic       done_nxt;
  logic       expire;

  // The cooldown run-down shows as gear 2 to the user.
  function automatic mode_t mode_of(input state_t s);
    case (s)
      S_GEAR1:    mode_of = M_GEAR1;
      S_GEAR2:    mode_of = M_GEAR2;
      S_COOLDOWN: mode_of = M_GEAR2;
      S_GEAR3:    mode_of = M_GEAR3;
      S_CLEAN:    mode_of = M_CLEAN;
      default:    mode_of = M_IDLE;
    endcase
  endfunction

  // A tick seen at 1 (or 0, which should not occur) ends the timed state; no wrap below zero.
  assign expire = tick_1hz && (remain_sec <= 8'd1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nxt  = state;
    remain_nxt = remain_sec;
    done_nxt   = 1'b0;

    if (!power_on) begin
      state_nxt  = S_OFF;
      remain_nxt = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          state_nxt  = S_STANDBY;
          remain_nxt = '0;
        end

        S_STANDBY: begin
          if (menu_btn) state_nxt = S_MENU;
        end

        S_MENU: begin
          if (menu_btn) begin
            state_nxt = S_STANDBY;
          end else if (clean_btn) begin
            state_nxt  = S_CLEAN;
            remain_nxt = CLEAN_LOAD;
          end else if (mode3_btn) begin
            // An unavailable gear 3 consumes the press and stays in the menu.
            if (gear3_avail) begin
              state_nxt  = S_GEAR3;
              remain_nxt = GEAR3_LOAD;
            end
          end else if (mode2_btn) begin
            state_nxt = S_GEAR2;
          end else if (mode1_btn) begin
            state_nxt = S_GEAR1;
          end
        end

        S_GEAR1, S_GEAR2: begin
          if (menu_btn) begin
            state_nxt = S_STANDBY;
          end else if (mode3_btn) begin
            if (gear3_avail) begin
              state_nxt  = S_GEAR3;
              remain_nxt = GEAR3_LOAD;
            end
          end else if (mode2_btn) begin
            state_nxt = S_GEAR2;
          end else if (mode1_btn) begin
            state_nxt = S_GEAR1;
          end
        end

        S_GEAR3: begin
          // Menu wins over a coincident tick, so the freshly loaded run-down is not decremented.
          if (menu_btn) begin
            state_nxt  = S_COOLDOWN;
            remain_nxt = COOLDOWN_LOAD;
          end else if (expire) begin
            state_nxt  = S_GEAR2;
            remain_nxt = '0;
          end else if (tick_1hz) begin
            remain_nxt = remain_sec - 8'd1;
          end
        end

        S_COOLDOWN: begin
          if (expire) begin
            state_nxt  = S_STANDBY;
            remain_nxt = '0;
          end else if (tick_1hz) begin
            remain_nxt = remain_sec - 8'd1;
          end
        end

        S_CLEAN: begin
          if (expire) begin
            state_nxt  = S_STANDBY;
            remain_nxt = '0;
            done_nxt   = 1'b1;
          end else if (tick_1hz) begin
            remain_nxt = remain_sec - 8'd1;
          end
        end

        default: begin
          state_nxt  = S_OFF;
          remain_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_OFF;
      remain_sec  <= '0;
      clean_done  <= 1'b0;
      mode_state  <= M_IDLE;
      menu_active <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state       <= state_nxt;
      remain_sec  <= remain_nxt;
      clean_done  <= done_nxt;
      mode_state  <= mode_of(state_nxt);
      menu_active <= (state_nxt == S_MENU);
    end
  end

`ifdef HOOD_GEAR3_ONCE_EN
  logic gear3_enter;
  logic gear3_rearm;

  assign gear3_enter = (state_nxt == S_GEAR3) && (state != S_GEAR3);
  assign gear3_rearm = (state == S_OFF) && (state_nxt == S_STANDBY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gear3_avail <= 1'b1;
    end else if (gear3_rearm) begin
      gear3_avail <= 1'b1;
    end else if (gear3_enter) begin
      gear3_avail <= 1'b0;
    end
  end
`else
  assign gear3_avail = 1'b1;
`endif

endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 Parameter GEAR3_SEC, default 60, gear-3 run time in seconds.
REQ-002 Parameter COOLDOWN_SEC, default 60, gear-2 run-down time after leaving gear 3 via the menu button.
REQ-003 Parameter CLEAN_SEC, default 180, self-clean duration in seconds; all parameters SHALL be in the range 1..255.
REQ-004 clk  input  1  system clock; reset is asynchronous and active-low; reset  input  1.
REQ-005 tick_1hz  input  1  single-cycle pulse once per second, synchronous to clk.
REQ-006 power_on  input  1  machine on/off level (1 = on).
REQ-007 menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn  input  1 each  debounced single-cycle press pulses.
REQ-008 mode_state  output  3  fan mode: 000 standby/off, 001 gear1, 010 gear2, 011 gear3, 100 self-clean.
REQ-009 menu_active  output  1  high only in MENU.
REQ-010 remain_sec  output  8  seconds left in a timed state; 0 otherwise.
REQ-011 clean_done  output  1  one-cycle pulse on self-clean completion.
REQ-012 gear3_avail  output  1  gear 3 may currently be entered.

Function
REQ-013 FSM states: OFF, STANDBY, MENU, GEAR1, GEAR2, GEAR3, COOLDOWN, CLEAN; outputs SHALL be registered, with transitions visible one cycle after the causing input.
REQ-014 power_on low SHALL force OFF from any state on the next clock, clearing remain_sec; in OFF all buttons are ignored.
REQ-015 OFF with power_on high -> STANDBY; entering STANDBY from OFF re-arms gear3_avail.
REQ-016 STANDBY: menu_btn -> MENU; all other buttons are ignored.
REQ-017 MENU: mode1 -> GEAR1, mode2 -> GEAR2, mode3 -> GEAR3 (only if gear3_avail, else stay in MENU), clean -> CLEAN, menu -> STANDBY.
REQ-018 Simultaneous presses in MENU resolve by priority menu > clean > mode3 > mode2 > mode1.
REQ-019 GEAR1/GEAR2: mode1 -> GEAR1, mode2 -> GEAR2, mode3 -> GEAR3 (if gear3_avail), menu -> STANDBY; clean is ignored; priority menu > mode3 > mode2 > mode1.
REQ-020 Entering GEAR3 loads remain_sec = GEAR3_SEC; each tick_1hz decrements it; the tick that takes it 1 -> 0 moves to GEAR2 with remain_sec = 0.
REQ-021 GEAR3: menu -> COOLDOWN with remain_sec = COOLDOWN_SEC; mode buttons are ignored.
REQ-022 COOLDOWN: mode_state = 010, decrement per tick, 1 -> 0 moves to STANDBY; all buttons are ignored.
REQ-023 Entering CLEAN loads remain_sec = CLEAN_SEC; decrement per tick; 1 -> 0 moves to STANDBY and asserts clean_done for exactly one cycle; all buttons are ignored.
REQ-024 A tick_1hz in the same cycle as a state-entering transition SHALL NOT decrement the newly loaded count.
REQ-025 remain_sec SHALL never wrap below 0.
REQ-026 menu_active = 1 only in MENU; mode_state = 000 in OFF, STANDBY and MENU.

Reset
REQ-027 reset low SHALL asynchronously force OFF, mode_state = 000, menu_active = 0, remain_sec = 0, clean_done = 0 and gear3_avail = 1.
REQ-028 Reset asserted mid-countdown SHALL discard the count; after release the block resumes from OFF (REQ-015).

Configuration
REQ-029 Macro HOOD_GEAR3_ONCE_EN defined: entering GEAR3 clears gear3_avail until the next OFF -> STANDBY transition or reset.
REQ-030 Macro HOOD_GEAR3_ONCE_EN undefined: gear3_avail is constant 1 and gear 3 is unlimited.

Verification
REQ-031 Reset, power_on = 1, menu, mode2 -> STANDBY, then MENU (menu_active = 1), then mode_state = 010 one cycle after each press.
REQ-032 From GEAR1, press mode3, apply 60 ticks -> mode_state = 011 with remain_sec 60..1, then 010 after the 60th tick.
REQ-033 From GEAR3 at remain_sec = 40, press menu -> COOLDOWN, mode_state = 010, remain_sec = 60; 60 ticks -> STANDBY.
REQ-034 From MENU, press clean, apply 180 ticks -> mode_state = 100; on the final tick mode_state = 000 and clean_done is high for one cycle; menu and mode presses during CLEAN have no effect.
REQ-035 With HOOD_GEAR3_ONCE_EN, after one gear-3 use: mode3 in MENU leaves menu_active = 1 and gear3_avail = 0; a power_on 1 -> 0 -> 1 cycle restores gear3_avail = 1.
REQ-036 menu and mode1 pressed in the same cycle in MENU -> STANDBY; power_on dropped during CLEAN -> OFF next cycle, remain_sec = 0, no clean_done.
